keypad_scanner: RTL and testbench

// Front end of the calculator: scans a 4x4 matrix keypad, debounces it, and drives
//   the controller's button interface.

---
 rtl/calc_pkg.sv | 51 +++++
 rtl/sync_bits.sv | 42 ++++
 rtl/keypad_scanner.sv | 168 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator types for the keypad front end.
//   active_button_t : every button the controller understands, plus B_NONE
//   keypad_state_e  : scanner FSM states
//   KEYMAP          : physical key position (row*4 + col) to button
//   is_single_low   : true when exactly one bit of a row/col vector is low
//   low_index       : position of the low bit in a one-hot-low nibble
package calc_pkg;

    typedef enum logic [4:0] {
        B_NONE,
        B_NUM_0, B_NUM_1, B_NUM_2, B_NUM_3, B_NUM_4,
        B_NUM_5, B_NUM_6, B_NUM_7, B_NUM_8, B_NUM_9,
        B_OP_ADD, B_OP_SUB, B_OP_MUL, B_OP_DIV,
        B_OP_EQ,
        B_CLEAR
    } active_button_t;

    typedef enum logic [1:0] {
        KS_SCAN,
        KS_DEBOUNCE,
        KS_HELD
    } keypad_state_e;

    // Keypad legend, row-major:
    //   row0: 1 2 3 +   row1: 4 5 6 -   row2: 7 8 9 *   row3: C 0 = /
    localparam active_button_t KEYMAP [16] = '{
        B_NUM_1, B_NUM_2, B_NUM_3, B_OP_ADD,
        B_NUM_4, B_NUM_5, B_NUM_6, B_OP_SUB,
        B_NUM_7, B_NUM_8, B_NUM_9, B_OP_MUL,
        B_CLEAR, B_NUM_0, B_OP_EQ, B_OP_DIV
    };

    // Two or more low rows in one column is treated as no press (ghost rejection).
    function automatic logic is_single_low(input logic [3:0] v);
        return ($countones(~v) == 1);
    endfunction

    // Only meaningful for one-hot-low inputs; anything else maps to 0.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/sync_bits.sv
// Multi-stage synchroniser for asynchronous inputs.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, loads all stages with ones
//   d_i    : asynchronous input bits
//   q_o    : synchronised bits, STAGES cycles behind d_i
module sync_bits #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    // Each stage takes the previous one; stage 0 takes the raw pins.
    always_comb begin
        stage_d[0] = d_i;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Reset to all-ones so released (pulled-up) rows are seen while in reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '1;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce, feeding the calculator controller.
//   clk_i           : system clock
//   rst_ni          : asynchronous active-low reset (deasserted synchronously inside)
//   row_ni          : keypad rows, pulled up, low = key closed in the driven column
//   col_no          : column drive, one-hot-low, rotates while scanning
//   active_button_o : last accepted key, held until the next accepted press
//   new_input_o     : one-cycle pulse per accepted press
//   key_held_o      : high from acceptance until a debounced release
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_CYCLES     = 1000,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [3:0]     row_ni,
    output logic [3:0]     col_no,
    output active_button_t active_button_o,
    output logic           new_input_o,
    output logic           key_held_o
);

    localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       rst_pipe_q, rst_pipe_d;
    logic             rst_int_n;
    logic [3:0]       row_s;

    keypad_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       col_q, col_d;
    logic [3:0]       pat_q, pat_d;
    active_button_t   btn_q, btn_d;
    logic             new_q, new_d;
    logic             held_q, held_d;

    logic [3:0]       col_next;
    logic [3:0]       key_idx;

    // Reset bridge: assertion reaches every flop at once, release is
    // aligned to the clock so no flop leaves reset on a different edge.
    always_comb begin
        rst_pipe_d = {rst_pipe_q[0], 1'b1};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_pipe_q <= 2'b00;
        end else begin
            rst_pipe_q <= rst_pipe_d;
        end
    end

    assign rst_int_n = rst_pipe_q[1];

    sync_bits #(
        .WIDTH  (4),
        .STAGES (SYNC_STAGES)
    ) u_row_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_int_n),
        .d_i    (row_ni),
        .q_o    (row_s)
    );

    assign col_next = {col_q[2:0], col_q[3]};
    assign key_idx  = {low_index(pat_q), low_index(col_q)};

    // Next-state logic. The column only moves when leaving a column without
    // a candidate key, when a debounce fails, or after a debounced release,
    // so the latched column always matches the key being tracked.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        pat_d   = pat_q;
        btn_d   = btn_q;
        new_d   = 1'b0;
        held_d  = held_q;

        case (state_q)
            KS_SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    if (is_single_low(row_s)) begin
                        pat_d   = row_s;
                        state_d = KS_DEBOUNCE;
                    end else begin
                        col_d = col_next;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            KS_DEBOUNCE: begin
                if (row_s == pat_q) begin
                    if (cnt_q == DEB_LAST) begin
                        cnt_d   = '0;
                        new_d   = 1'b1;
                        btn_d   = KEYMAP[key_idx];
                        held_d  = 1'b1;
                        state_d = KS_HELD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d   = '0;
                    col_d   = col_next;
                    state_d = KS_SCAN;
                end
            end

            KS_HELD: begin
                // Any low row, including a second key, restarts the release count.
                if (row_s == 4'hF) begin
                    if (cnt_q == DEB_LAST) begin
                        cnt_d   = '0;
                        held_d  = 1'b0;
                        col_d   = col_next;
                        state_d = KS_SCAN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = KS_SCAN;
            end
        endcase
    end

    // All scanner state and registered outputs.
    always_ff @(posedge clk_i or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= KS_SCAN;
            cnt_q   <= '0;
            col_q   <= 4'b1110;
            pat_q   <= 4'hF;
            btn_q   <= B_NONE;
            new_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            pat_q   <= pat_d;
            btn_q   <= btn_d;
            new_q   <= new_d;
            held_q  <= held_d;
        end
    end

    assign col_no          = col_q;
    assign active_button_o = btn_q;
    assign new_input_o     = new_q;
    assign key_held_o      = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner. A keypad model turns a 16-bit
// "keys pressed" vector into row levels for whatever column is driven; the
// expectations come from the keypad legend and the latency rules of the scanner.
module tb_keypad_scanner;
    import calc_pkg::*;

    localparam int SCAN  = 4;
    localparam int DEB   = 8;
    localparam int SYNC  = 2;
    localparam int LAT_MIN = SYNC + DEB + 1;
    localparam int LAT_MAX = LAT_MIN + 4 * SCAN + 2;
    localparam int REL_LAT = SYNC + DEB;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic [3:0]     row_ni;
    logic [3:0]     col_no;
    active_button_t active_button_o;
    logic           new_input_o;
    logic           key_held_o;

    logic [15:0]    keys;

    int checks_total  = 0;
    int checks_passed = 0;

    int             cycle = 0;
    int             pulse_count = 0;
    int             pulse_cycle = 0;
    active_button_t pulse_btn = B_NONE;
    bit             double_pulse = 0;
    bit             col_bad = 0;
    logic           prev_new = 1'b0;

    always #5 clk_i = ~clk_i;

    keypad_scanner #(
        .SCAN_CYCLES     (SCAN),
        .DEBOUNCE_CYCLES (DEB),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .row_ni          (row_ni),
        .col_no          (col_no),
        .active_button_o (active_button_o),
        .new_input_o     (new_input_o),
        .key_held_o      (key_held_o)
    );

    // Keypad matrix: a pressed key pulls its row low only while its column is driven.
    always_comb begin
        row_ni = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && (col_no[c] === 1'b0)) begin
                    row_ni[r] = 1'b0;
                end
            end
        end
    end

    // Observe outputs on the falling edge, well away from the active edge.
    always @(negedge clk_i) begin
        cycle = cycle + 1;
        if (new_input_o === 1'b1) begin
            pulse_count = pulse_count + 1;
            pulse_btn   = active_button_o;
            pulse_cycle = cycle;
            if (prev_new === 1'b1) double_pulse = 1;
        end
        prev_new = new_input_o;
        if (rst_ni === 1'b1 && $countones(~col_no) != 1) col_bad = 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic active_button_t expected_button(input int r, input int c);
        case (r * 4 + c)
            0:  return B_NUM_1;
            1:  return B_NUM_2;
            2:  return B_NUM_3;
            3:  return B_OP_ADD;
            4:  return B_NUM_4;
            5:  return B_NUM_5;
            6:  return B_NUM_6;
            7:  return B_OP_SUB;
            8:  return B_NUM_7;
            9:  return B_NUM_8;
            10: return B_NUM_9;
            11: return B_OP_MUL;
            12: return B_CLEAR;
            13: return B_NUM_0;
            14: return B_OP_EQ;
            default: return B_OP_DIV;
        endcase
    endfunction

    function automatic int idx_of_low(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i] === 1'b0) return i;
        end
        return -1;
    endfunction

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic wait_for_pulse(input int base, input int limit, output int waited);
        waited = 0;
        while (pulse_count == base && waited < limit) begin
            tick();
            waited++;
        end
    endtask

    task automatic wait_release(input int limit, output int waited);
        waited = 0;
        while (key_held_o === 1'b1 && waited < limit) begin
            tick();
            waited++;
        end
    endtask

    task automatic test_reset();
        logic [3:0] obs [32];
        int last_change, changes, base;
        keys   = '0;
        rst_ni = 1'b0;
        repeat (3) tick();
        checks_total++;
        if (col_no !== 4'b1110) $display("[TB] FAIL reset_col: got %b want 1110", col_no);
        else checks_passed++;
        checks_total++;
        if (active_button_o !== B_NONE) $display("[TB] FAIL reset_btn: got %s want B_NONE", active_button_o.name());
        else checks_passed++;
        checks_total++;
        if (new_input_o !== 1'b0) $display("[TB] FAIL reset_new: got %b want 0", new_input_o);
        else checks_passed++;
        checks_total++;
        if (key_held_o !== 1'b0) $display("[TB] FAIL reset_held: got %b want 0", key_held_o);
        else checks_passed++;

        base    = pulse_count;
        col_bad = 0;
        rst_ni  = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            obs[i] = col_no;
        end
        checks_total++;
        if (obs[0] !== 4'b1110) $display("[TB] FAIL idle_first_col: got %b want 1110", obs[0]);
        else checks_passed++;
        checks_total++;
        if (col_bad) $display("[TB] FAIL idle_onehot: got non one-hot-low column want one-hot-low");
        else checks_passed++;
        checks_total++;
        if (pulse_count != base) $display("[TB] FAIL idle_no_pulse: got %0d pulses want 0", pulse_count - base);
        else checks_passed++;
        checks_total++;
        if (active_button_o !== B_NONE) $display("[TB] FAIL idle_btn: got %s want B_NONE", active_button_o.name());
        else checks_passed++;

        last_change = -1;
        changes     = 0;
        for (int i = 1; i < 32; i++) begin
            if (obs[i] !== obs[i-1]) begin
                changes++;
                checks_total++;
                if (idx_of_low(obs[i]) != (idx_of_low(obs[i-1]) + 1) % 4)
                    $display("[TB] FAIL idle_rotate: got %b after %b want next column", obs[i], obs[i-1]);
                else checks_passed++;
                if (last_change >= 0) begin
                    checks_total++;
                    if (i - last_change != SCAN)
                        $display("[TB] FAIL idle_period: got %0d cycles want %0d", i - last_change, SCAN);
                    else checks_passed++;
                end
                last_change = i;
            end
        end
        checks_total++;
        if (changes < 6) $display("[TB] FAIL idle_changes: got %0d want >= 6", changes);
        else checks_passed++;
    endtask

    task automatic test_clean_press(input int r, input int c, input int hold_cycles, input string tag);
        int base, press_cycle, waited, lat;
        active_button_t exp_btn;
        exp_btn = expected_button(r, c);
        base    = pulse_count;
        keys    = '0;
        keys[r*4+c] = 1'b1;
        press_cycle = cycle;
        for (int i = 0; i < hold_cycles; i++) tick();
        checks_total++;
        if (pulse_count != base + 1) $display("[TB] FAIL %s_pulses: got %0d want 1", tag, pulse_count - base);
        else checks_passed++;
        checks_total++;
        if (pulse_btn !== exp_btn) $display("[TB] FAIL %s_btn: got %s want %s", tag, pulse_btn.name(), exp_btn.name());
        else checks_passed++;
        lat = pulse_cycle - press_cycle;
        checks_total++;
        if (lat < LAT_MIN || lat > LAT_MAX)
            $display("[TB] FAIL %s_latency: got %0d want %0d..%0d", tag, lat, LAT_MIN, LAT_MAX);
        else checks_passed++;
        checks_total++;
        if (key_held_o !== 1'b1) $display("[TB] FAIL %s_held: got %b want 1", tag, key_held_o);
        else checks_passed++;

        keys = '0;
        wait_release(40, waited);
        checks_total++;
        if (waited != REL_LAT) $display("[TB] FAIL %s_release: got %0d cycles want %0d", tag, waited, REL_LAT);
        else checks_passed++;
        tick();
        checks_total++;
        if (active_button_o !== exp_btn || pulse_count != base + 1)
            $display("[TB] FAIL %s_sticky: got %s/%0d pulses want %s/1", tag, active_button_o.name(),
                     pulse_count - base, exp_btn.name());
        else checks_passed++;
    endtask

    task automatic test_single_press();
        test_clean_press(0, 0, 100, "single");
    endtask

    task automatic test_bounce();
        int base, waited;
        base = pulse_count;
        keys = '0;
        for (int p = 0; p < 5; p++) begin
            keys[14] = 1'b1;
            repeat (3) tick();
            keys[14] = 1'b0;
            tick();
        end
        checks_total++;
        if (pulse_count != base) $display("[TB] FAIL bounce_quiet: got %0d pulses want 0", pulse_count - base);
        else checks_passed++;
        keys[14] = 1'b1;
        wait_for_pulse(base, LAT_MAX + 4, waited);
        checks_total++;
        if (pulse_count != base + 1) $display("[TB] FAIL bounce_pulse: got %0d pulses want 1", pulse_count - base);
        else checks_passed++;
        checks_total++;
        if (waited < LAT_MIN || waited > LAT_MAX)
            $display("[TB] FAIL bounce_latency: got %0d want %0d..%0d", waited, LAT_MIN, LAT_MAX);
        else checks_passed++;
        checks_total++;
        if (pulse_btn !== expected_button(3, 2)) $display("[TB] FAIL bounce_btn: got %s want B_OP_EQ", pulse_btn.name());
        else checks_passed++;
        repeat (20) tick();
        keys = '0;
        wait_release(40, waited);
        checks_total++;
        if (pulse_count != base + 1 || key_held_o !== 1'b0)
            $display("[TB] FAIL bounce_after: got %0d pulses held=%b want 1 held=0", pulse_count - base, key_held_o);
        else checks_passed++;
    endtask

    task automatic test_ghost();
        int base, waited;
        base    = pulse_count;
        keys    = '0;
        keys[1] = 1'b1;
        keys[5] = 1'b1;
        repeat (60) tick();
        checks_total++;
        if (pulse_count != base || key_held_o !== 1'b0)
            $display("[TB] FAIL ghost_reject: got %0d pulses held=%b want 0 held=0", pulse_count - base, key_held_o);
        else checks_passed++;
        keys[5] = 1'b0;
        wait_for_pulse(base, LAT_MAX + 4, waited);
        checks_total++;
        if (pulse_count != base + 1) $display("[TB] FAIL ghost_single_pulse: got %0d want 1", pulse_count - base);
        else checks_passed++;
        checks_total++;
        if (pulse_btn !== expected_button(0, 1)) $display("[TB] FAIL ghost_btn: got %s want B_NUM_2", pulse_btn.name());
        else checks_passed++;
        keys = '0;
        wait_release(40, waited);
        checks_total++;
        if (waited != REL_LAT) $display("[TB] FAIL ghost_release: got %0d cycles want %0d", waited, REL_LAT);
        else checks_passed++;
    endtask

    task automatic test_held_ignore();
        int base, waited;
        base    = pulse_count;
        keys    = '0;
        keys[8] = 1'b1;
        wait_for_pulse(base, LAT_MAX + 4, waited);
        checks_total++;
        if (pulse_btn !== expected_button(2, 0) || pulse_count != base + 1)
            $display("[TB] FAIL held_first: got %s/%0d want B_NUM_7/1", pulse_btn.name(), pulse_count - base);
        else checks_passed++;
        keys[0] = 1'b1;
        repeat (40) tick();
        checks_total++;
        if (pulse_count != base + 1 || active_button_o !== expected_button(2, 0) || key_held_o !== 1'b1)
            $display("[TB] FAIL held_second_key: got %0d pulses %s held=%b want 1 B_NUM_7 held=1",
                     pulse_count - base, active_button_o.name(), key_held_o);
        else checks_passed++;
        keys[0] = 1'b0;
        repeat (3) tick();
        keys[8] = 1'b0;
        wait_release(40, waited);
        checks_total++;
        if (waited != REL_LAT) $display("[TB] FAIL held_release: got %0d cycles want %0d", waited, REL_LAT);
        else checks_passed++;
    endtask

    task automatic test_random_keys();
        int k, hold;
        for (int n = 0; n < 6; n++) begin
            k    = $urandom_range(0, 15);
            hold = 40 + $urandom_range(0, 40);
            test_clean_press(k / 4, k % 4, hold, $sformatf("rand%0d_k%0d", n, k));
            repeat ($urandom_range(0, 7)) tick();
        end
    endtask

    task automatic test_reset_mid_debounce();
        int base, waited;
        base    = pulse_count;
        keys    = '0;
        keys[1] = 1'b1;
        waited  = 0;
        while (col_no === 4'b1101 && waited < 40) begin
            tick();
            waited++;
        end
        waited = 0;
        while (col_no !== 4'b1101 && waited < 40) begin
            tick();
            waited++;
        end
        checks_total++;
        if (col_no !== 4'b1101) $display("[TB] FAIL rstmid_col_reach: got %b want 1101", col_no);
        else checks_passed++;
        repeat (6) tick();
        checks_total++;
        if (pulse_count != base) $display("[TB] FAIL rstmid_early: got %0d pulses want 0", pulse_count - base);
        else checks_passed++;
        rst_ni = 1'b0;
        #1;
        checks_total++;
        if (col_no !== 4'b1110 || active_button_o !== B_NONE || new_input_o !== 1'b0 || key_held_o !== 1'b0)
            $display("[TB] FAIL rstmid_outputs: got col=%b btn=%s new=%b held=%b want 1110 B_NONE 0 0",
                     col_no, active_button_o.name(), new_input_o, key_held_o);
        else checks_passed++;
        tick();
        rst_ni = 1'b1;
        wait_for_pulse(base, 60, waited);
        checks_total++;
        if (pulse_count != base + 1) $display("[TB] FAIL rstmid_pulses: got %0d want 1", pulse_count - base);
        else checks_passed++;
        checks_total++;
        if (waited < LAT_MIN) $display("[TB] FAIL rstmid_fresh: got %0d cycles want >= %0d", waited, LAT_MIN);
        else checks_passed++;
        checks_total++;
        if (pulse_btn !== B_NUM_2) $display("[TB] FAIL rstmid_btn: got %s want B_NUM_2", pulse_btn.name());
        else checks_passed++;
        keys = '0;
        wait_release(40, waited);
        checks_total++;
        if (waited != REL_LAT) $display("[TB] FAIL rstmid_release: got %0d cycles want %0d", waited, REL_LAT);
        else checks_passed++;
    endtask

    task automatic test_invariants();
        checks_total++;
        if (double_pulse) $display("[TB] FAIL pulse_width: got multi-cycle pulse want single cycle");
        else checks_passed++;
        checks_total++;
        if (col_bad) $display("[TB] FAIL col_onehot: got non one-hot-low column want one-hot-low");
        else checks_passed++;
    endtask

    initial begin
        rst_ni = 1'b0;
        keys   = '0;
        test_reset();
        test_single_press();
        test_bounce();
        test_ghost();
        test_held_ignore();
        test_random_keys();
        test_reset_mid_debounce();
        test_invariants();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
